// File: rtl/fifo2axi_pkg.sv
// Shared types and constants for the FIFO-to-AXI4 write bridge.
// States, command word layout, AXI encodings and a beat-to-byte helper.
package fifo2axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } state_e;

  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_MSB = 31;
  localparam int CMD_CNT_LSB  = 32;
  localparam int CMD_CNT_MSB  = 47;
  localparam int CMD_IRQ_BIT  = 63;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;

  // Burst length fits MAX_BURST <= 16
  localparam int LEN_W = 5;

  // Each beat moves 16 bytes
  function automatic logic [8:0] beats_to_bytes(input logic [LEN_W-1:0] beats);
    return {beats, 4'b0000};
  endfunction

endpackage

// File: rtl/fifo2axi_wr_if.sv
// Command FIFO, data FIFO and AXI4 write-channel bundle for fifo2axi_wr.
// master = bridge side, slave = FIFO/AXI environment side.
interface fifo2axi_wr_if #(
  parameter int ADDR_W = 32
);
  logic [63:0]       cmd_dout;
  logic              cmd_empty;
  logic              cmd_rd_en;
  logic [127:0]      wr_dout;
  logic              wr_empty;
  logic              wr_rd_en;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0]        m_awlen;
  logic [2:0]        m_awsize;
  logic [1:0]        m_awburst;
  logic              m_awvalid;
  logic              m_awready;
  logic [127:0]      m_wdata;
  logic [15:0]       m_wstrb;
  logic              m_wlast;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  modport master (
    input  cmd_dout, cmd_empty, wr_dout, wr_empty,
    output cmd_rd_en, wr_rd_en,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output cmd_dout, cmd_empty, wr_dout, wr_empty,
    input  cmd_rd_en, wr_rd_en,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/fifo2axi_burst_calc.sv
// Combinational burst sizer: min(remaining, MAX_BURST, beats left in the 4 KB page).
// blk_off is address bits [11:4], the 16-byte beat index inside the page.
module fifo2axi_burst_calc
  import fifo2axi_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [7:0]       blk_off,
  input  logic [15:0]      remaining,
  output logic [LEN_W-1:0] len
);

  logic [15:0] to_bound_s;
  logic [15:0] cap_s;

  assign to_bound_s = 16'd256 - {8'd0, blk_off};
  assign cap_s      = (to_bound_s < 16'(MAX_BURST)) ? to_bound_s : 16'(MAX_BURST);
  assign len        = LEN_W'((remaining < cap_s) ? remaining : cap_s);

endmodule

// File: rtl/fifo2axi_wr.sv
// Drains address/count commands and 128-bit data from FWFT FIFOs into AXI4 INCR write bursts.
// Optional macro FIFO2AXI_WR_BRESP_CHK_EN makes a non-OKAY write response set the sticky err flag.
module fifo2axi_wr
  import fifo2axi_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fifo2axi_wr_if.master bus,
  output logic          busy,
  output logic          done_irq,
  output logic          err
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_LOAD = ST_LOAD;
  localparam logic [2:0] S_AW   = ST_AW;
  localparam logic [2:0] S_W    = ST_W;
  localparam logic [2:0] S_B    = ST_B;

  logic [2:0]        state_r, state_nxt_s;
  logic              cmd_rd_en_r, busy_r, done_irq_r, irq_r;
  logic              aw_valid_r, w_last_r, b_ready_r;
  logic [ADDR_W-1:0] aw_addr_r, addr_r, addr_nxt_s, cmd_addr_s;
  logic [7:0]        aw_len_r;
  logic [2:0]        aw_size_r;
  logic [1:0]        aw_burst_r;
  logic [15:0]       rem_r, rem_nxt_s, cmd_cnt_s, calc_rem_s;
  logic [7:0]        calc_blk_s;
  logic [LEN_W-1:0]  len_r, beat_cnt_r, calc_len_s;
  logic              in_w_s, aw_hs_s, w_hs_s, b_hs_s;
  logic              unused_s;

  assign cmd_addr_s = ADDR_W'(bus.cmd_dout[CMD_ADDR_MSB:CMD_ADDR_LSB]);
  assign cmd_cnt_s  = bus.cmd_dout[CMD_CNT_MSB:CMD_CNT_LSB];
  assign addr_nxt_s = addr_r + ADDR_W'(beats_to_bytes(len_r));
  assign rem_nxt_s  = rem_r - 16'(len_r);

  assign in_w_s  = (state_r == S_W);
  assign aw_hs_s = aw_valid_r & bus.m_awready;
  assign w_hs_s  = bus.m_wvalid & bus.m_wready;
  assign b_hs_s  = b_ready_r & bus.m_bvalid;

  // Size the first burst from the fresh command, later bursts from the post-response pointers
  always_comb begin
    calc_blk_s = addr_nxt_s[11:4];
    calc_rem_s = rem_nxt_s;
    if (state_r == S_LOAD) begin
      calc_blk_s = cmd_addr_s[11:4];
      calc_rem_s = cmd_cnt_s;
    end else begin
      calc_blk_s = addr_nxt_s[11:4];
      calc_rem_s = rem_nxt_s;
    end
  end

  fifo2axi_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
    .blk_off   (calc_blk_s),
    .remaining (calc_rem_s),
    .len       (calc_len_s)
  );

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!bus.cmd_empty) state_nxt_s = S_LOAD;
        else                state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (cmd_cnt_s == 16'd0) state_nxt_s = S_IDLE;
        else                    state_nxt_s = S_AW;
      end
      S_AW: begin
        if (aw_hs_s) state_nxt_s = S_W;
        else         state_nxt_s = S_AW;
      end
      S_W: begin
        if (w_hs_s && w_last_r) state_nxt_s = S_B;
        else                    state_nxt_s = S_W;
      end
      S_B: begin
        if (b_hs_s && (rem_nxt_s != 16'd0)) state_nxt_s = S_AW;
        else if (b_hs_s)                    state_nxt_s = S_IDLE;
        else                                state_nxt_s = S_B;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM, burst bookkeeping and registered channel controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      cmd_rd_en_r <= 1'b0;
      busy_r      <= 1'b0;
      done_irq_r  <= 1'b0;
      irq_r       <= 1'b0;
      aw_valid_r  <= 1'b0;
      aw_addr_r   <= {ADDR_W{1'b0}};
      aw_len_r    <= 8'd0;
      aw_size_r   <= 3'd0;
      aw_burst_r  <= 2'd0;
      w_last_r    <= 1'b0;
      b_ready_r   <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      rem_r       <= 16'd0;
      len_r       <= {LEN_W{1'b0}};
      beat_cnt_r  <= {LEN_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cmd_rd_en_r <= (state_nxt_s == S_LOAD);
      busy_r      <= (state_nxt_s != S_IDLE);
      done_irq_r  <= 1'b0;
      case (state_r)
        S_LOAD: begin
          // cmd_dout still shows this word: the pop lands on this same edge
          addr_r <= cmd_addr_s;
          rem_r  <= cmd_cnt_s;
          irq_r  <= bus.cmd_dout[CMD_IRQ_BIT];
          if (cmd_cnt_s != 16'd0) begin
            aw_valid_r <= 1'b1;
            aw_addr_r  <= cmd_addr_s;
            aw_len_r   <= 8'(calc_len_s - 5'd1);
            aw_size_r  <= AXI_SIZE_16B;
            aw_burst_r <= AXI_BURST_INCR;
            len_r      <= calc_len_s;
          end
        end
        S_AW: begin
          if (aw_hs_s) begin
            aw_valid_r <= 1'b0;
            beat_cnt_r <= {LEN_W{1'b0}};
            w_last_r   <= (len_r == 5'd1);
          end
        end
        S_W: begin
          if (w_hs_s && w_last_r) begin
            w_last_r  <= 1'b0;
            b_ready_r <= 1'b1;
          end else if (w_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 5'd1;
            w_last_r   <= ((beat_cnt_r + 5'd2) == len_r);
          end
        end
        S_B: begin
          if (b_hs_s) begin
            b_ready_r <= 1'b0;
            addr_r    <= addr_nxt_s;
            rem_r     <= rem_nxt_s;
            if (rem_nxt_s != 16'd0) begin
              aw_valid_r <= 1'b1;
              aw_addr_r  <= addr_nxt_s;
              aw_len_r   <= 8'(calc_len_s - 5'd1);
              len_r      <= calc_len_s;
            end else begin
              done_irq_r <= irq_r;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_rd_en = cmd_rd_en_r;
  assign bus.m_awvalid = aw_valid_r;
  assign bus.m_awaddr  = aw_addr_r;
  assign bus.m_awlen   = aw_len_r;
  assign bus.m_awsize  = aw_size_r;
  assign bus.m_awburst = aw_burst_r;
  // Data beats follow the FWFT head directly so an empty FIFO never produces a beat
  assign bus.m_wvalid  = in_w_s & ~bus.wr_empty;
  assign bus.wr_rd_en  = bus.m_wvalid & bus.m_wready;
  assign bus.m_wdata   = in_w_s ? bus.wr_dout : {128{1'b0}};
  assign bus.m_wstrb   = in_w_s ? 16'hFFFF : 16'h0000;
  assign bus.m_wlast   = w_last_r;
  assign bus.m_bready  = b_ready_r;
  assign busy          = busy_r;
  assign done_irq      = done_irq_r;

`ifdef FIFO2AXI_WR_BRESP_CHK_EN
  logic err_r;

  // Sticky error on any non-OKAY write response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (b_hs_s && (bus.m_bresp != AXI_RESP_OKAY)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err      = err_r;
  assign unused_s = ^bus.cmd_dout[62:48];
`else
  assign err      = 1'b0;
  assign unused_s = ^{bus.cmd_dout[62:48], bus.m_bresp};
`endif

endmodule
